id_ex_issue: RTL and testbench
==============================

ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 Parameter FWD_EN, default 0: 1 = downstream forwarding present, hazards reduced to load-use only.
REQ-002 clk  in  1  rising-edge clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 freeze  in  1  memory-stall hold of whole pipe; flush  in  1  taken branch in EX, kill ID instruction.
REQ-004 in_valid  in  1  ID holds a real instruction; two_src  in  1  instruction reads src2.
REQ-005 src1, src2  in  4  ID read addresses, same values driven to register file.
REQ-006 dest_id  in  4  destination register; ctl_id  in  10  control bundle (see REQ-020).
REQ-007 reg1, reg2  in  32  register file read data for src1/src2; pc_id  in  32  PC+4 of ID instruction.
REQ-008 opnd_id  in  24  signed_imm24 / shift_operand field.
REQ-009 hazard  out  1  combinational; upstream freezes PC and IF/ID while high.
REQ-010 out_valid  out  1; dest_ex  out  4; ctl_ex  out  10; val_rn_ex, val_rm_ex  out  32; pc_ex  out  32; opnd_ex  out  24 -- EX-stage registered copies.

Function
REQ-011 Priority per rising edge: freeze > flush > hazard > load.
REQ-012 freeze=1: every register, including scoreboard, SHALL hold; flush/hazard ignored (upstream holds flush until freeze=0).
REQ-013 flush=1 (freeze=0): out_valid and ctl_ex SHALL be 0; data fields don't-care but SHALL be cleared to 0.
REQ-014 hazard=1 (freeze=0, flush=0): bubble inserted exactly as REQ-013; ID instruction not consumed.
REQ-015 Otherwise: all EX outputs SHALL load ID inputs; out_valid<=in_valid; ctl_ex<=in_valid?ctl_id:0.
REQ-016 Latency exactly 1 cycle ID->EX; no internal buffering beyond one entry.
REQ-017 Scoreboard: EX slot = {out_valid & ctl_ex.wb_en, dest_ex, ctl_ex.mem_r}; MEM slot registered copy, loaded from EX slot on every non-frozen edge (incl. flush/bubble edges).
REQ-018 FWD_EN=0: hazard = in_valid & ~flush & ((src1 matches valid EX or MEM slot) | (two_src & src2 matches valid EX or MEM slot)).
REQ-019 FWD_EN=1: hazard as REQ-018 but only valid EX slot with mem_r=1 counts; MEM slot ignored.
REQ-020 ctl bundle bits: [9] imm, [8] wb_en, [7] mem_r, [6] mem_w, [5:2] exe_cmd, [1] s, [0] b.
REQ-021 WB-stage destination SHALL NOT be tracked: register file writes on falling edge, same-cycle read sees new value.
REQ-022 in_valid=0: hazard SHALL be 0 regardless of addresses.
REQ-023 Register 15 compared like any other index; no special case.

Reset
REQ-024 rst=1: all outputs, both scoreboard slots SHALL be 0 immediately, independent of clk.
REQ-025 rst deassertion mid-stream: first edge after behaves as empty pipe (no hazard from pre-reset state).

Structure
REQ-026 Shared package: ctl bit positions, CTL_W=10, NOP ctl value 0, exe_cmd encodings.
REQ-027 One sub-module hazard_scoreboard (MEM slot register + compare logic, param FWD_EN); pipeline register in top.

Verification
REQ-028 Load ID {src1=3, dest=5, wb_en=1, reg1=0x11}, no stalls -> next edge out_valid=1, dest_ex=5, val_rn_ex=0x11.
REQ-029 EX holds wb_en dest=5; ID src1=5, FWD_EN=0 -> hazard=1 two cycles, two bubbles, then instruction issues.
REQ-030 Same as REQ-029 with FWD_EN=1, EX not load -> hazard=0; EX load (mem_r=1) -> exactly one bubble.
REQ-031 freeze=1 three cycles with flush=1 and hazard=1 asserted -> all outputs and slots unchanged; release -> flush applied.
REQ-032 ID two_src=0, src2=dest of EX -> hazard=0; two_src=1 -> hazard=1.
REQ-033 rst pulsed between clock edges while pipe full -> outputs 0 at once; next ID instruction issues with hazard=0.

Source files
------------

// File: rtl/id_ex_issue_pkg.sv
// rtl/id_ex_issue_pkg.sv - shared control-bundle layout and scoreboard types for the ID/EX issue stage
// Purpose: single source for control bit positions, the NOP control value,
//          exe_cmd encodings and the scoreboard slot record.
// Ports:   none (package).
package id_ex_issue_pkg;

   localparam int CTL_W       = 10;
   localparam int CTL_IMM     = 9;
   localparam int CTL_WB_EN   = 8;
   localparam int CTL_MEM_R   = 7;
   localparam int CTL_MEM_W   = 6;
   localparam int CTL_EXE_MSB = 5;
   localparam int CTL_EXE_LSB = 2;
   localparam int CTL_S       = 1;
   localparam int CTL_B       = 0;

   localparam logic [CTL_W-1:0] CTL_NOP = '0;

   typedef enum logic [3:0] {
      EXE_NOP = 4'h0,
      EXE_MOV = 4'h1,
      EXE_ADD = 4'h2,
      EXE_ADC = 4'h3,
      EXE_SUB = 4'h4,
      EXE_SBC = 4'h5,
      EXE_AND = 4'h6,
      EXE_ORR = 4'h7,
      EXE_EOR = 4'h8,
      EXE_MVN = 4'h9
   } exe_cmd_t;

   // One in-flight producer as seen by the hazard compare.
   typedef struct packed {
      logic       valid;
      logic [3:0] dest;
      logic       mem_r;
   } sb_slot_t;

endpackage

// File: rtl/id_ex_issue_hazard_scoreboard.sv
// rtl/id_ex_issue_hazard_scoreboard.sv - MEM-slot tracking and RAW hazard compare for the ID stage
// Purpose: holds the MEM-stage copy of the EX scoreboard slot and compares
//          the ID read addresses against the in-flight producers.
// Ports:   clk, rst      - clock, async active-high reset
//          freeze, flush - pipe hold / branch kill of the ID instruction
//          in_valid, two_src, src1, src2 - ID instruction read set
//          ex_slot       - scoreboard view of the EX register
//          hazard        - combinational stall request
module hazard_scoreboard
   import id_ex_issue_pkg::*;
#(
   parameter bit FWD_EN = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       freeze,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       two_src,
   input  logic [3:0] src1,
   input  logic [3:0] src2,
   input  sb_slot_t   ex_slot,
   output logic       hazard
);

   sb_slot_t mem_slot;
   logic     hit1;
   logic     hit2;

   // Bubbles and flushes still advance the MEM copy; only a freeze holds it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_slot <= '0;
      end else if (!freeze) begin
         mem_slot <= ex_slot;
      end
   end

   // WB is not tracked: the register file writes on the falling edge, so an
   // ID read in the same cycle already sees the new value.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      if (FWD_EN) begin
         // Forwarding covers everything except a load still in EX.
         hit1 = ex_slot.valid & ex_slot.mem_r & (ex_slot.dest == src1);
         hit2 = ex_slot.valid & ex_slot.mem_r & (ex_slot.dest == src2);
      end else begin
         hit1 = (ex_slot.valid  & (ex_slot.dest  == src1)) |
                (mem_slot.valid & (mem_slot.dest == src1));
         hit2 = (ex_slot.valid  & (ex_slot.dest  == src2)) |
                (mem_slot.valid & (mem_slot.dest == src2));
      end
      hazard = in_valid & ~flush & (hit1 | (two_src & hit2));
   end

endmodule

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX pipeline register with hazard-driven bubble insertion
// Purpose: registers the decoded instruction into EX, inserting bubbles on
//          flush or RAW hazard and holding everything on freeze.
// Ports:   clk, rst            - clock, async active-high reset
//          freeze, flush       - memory-stall hold / taken-branch kill
//          in_valid, two_src, src1, src2, dest_id, ctl_id - ID decode
//          reg1, reg2, pc_id, opnd_id - ID operand data
//          hazard              - combinational stall to PC and IF/ID
//          out_valid, dest_ex, ctl_ex, val_rn_ex, val_rm_ex, pc_ex, opnd_ex - EX copies
module id_ex_issue
   import id_ex_issue_pkg::*;
#(
   parameter bit FWD_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             two_src,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic [3:0]       dest_id,
   input  logic [CTL_W-1:0] ctl_id,
   input  logic [31:0]      reg1,
   input  logic [31:0]      reg2,
   input  logic [31:0]      pc_id,
   input  logic [23:0]      opnd_id,
   output logic             hazard,
   output logic             out_valid,
   output logic [3:0]       dest_ex,
   output logic [CTL_W-1:0] ctl_ex,
   output logic [31:0]      val_rn_ex,
   output logic [31:0]      val_rm_ex,
   output logic [31:0]      pc_ex,
   output logic [23:0]      opnd_ex
);

   sb_slot_t ex_slot;

   assign ex_slot.valid = out_valid & ctl_ex[CTL_WB_EN];
   assign ex_slot.dest  = dest_ex;
   assign ex_slot.mem_r = ctl_ex[CTL_MEM_R];

   hazard_scoreboard #(
      .FWD_EN (FWD_EN)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .freeze   (freeze),
      .flush    (flush),
      .in_valid (in_valid),
      .two_src  (two_src),
      .src1     (src1),
      .src2     (src2),
      .ex_slot  (ex_slot),
      .hazard   (hazard)
   );

   // freeze > flush > hazard > load. A bubble clears the data fields too so
   // EX never sees stale operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         dest_ex   <= '0;
         ctl_ex    <= CTL_NOP;
         val_rn_ex <= '0;
         val_rm_ex <= '0;
         pc_ex     <= '0;
         opnd_ex   <= '0;
      end else if (!freeze) begin
         if (flush || hazard) begin
            out_valid <= 1'b0;
            dest_ex   <= '0;
            ctl_ex    <= CTL_NOP;
            val_rn_ex <= '0;
            val_rm_ex <= '0;
            pc_ex     <= '0;
            opnd_ex   <= '0;
         end else begin
            out_valid <= in_valid;
            dest_ex   <= dest_id;
            ctl_ex    <= in_valid ? ctl_id : CTL_NOP;
            val_rn_ex <= reg1;
            val_rm_ex <= reg2;
            pc_ex     <= pc_id;
            opnd_ex   <= opnd_id;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_issue.sv
// tb/tb_id_ex_issue.sv - directed self-checking bench for id_ex_issue (both FWD_EN settings)
module tb_id_ex_issue;
   import id_ex_issue_pkg::*;

   localparam logic [CTL_W-1:0] C_WB = 10'h108;  // wb_en, exe_cmd=ADD
   localparam logic [CTL_W-1:0] C_LD = 10'h188;  // wb_en, mem_r, exe_cmd=ADD

   logic             clk;
   logic             rst;
   logic             freeze;
   logic             flush;
   logic             in_valid;
   logic             two_src;
   logic [3:0]       src1;
   logic [3:0]       src2;
   logic [3:0]       dest_id;
   logic [CTL_W-1:0] ctl_id;
   logic [31:0]      reg1;
   logic [31:0]      reg2;
   logic [31:0]      pc_id;
   logic [23:0]      opnd_id;

   logic             hz0, ov0, hz1, ov1;
   logic [3:0]       dx0, dx1;
   logic [CTL_W-1:0] cx0, cx1;
   logic [31:0]      rn0, rm0, pc0, rn1, rm1, pc1;
   logic [23:0]      op0, op1;

   int checks;
   int failures;

   id_ex_issue #(.FWD_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .two_src(two_src), .src1(src1), .src2(src2),
      .dest_id(dest_id), .ctl_id(ctl_id), .reg1(reg1), .reg2(reg2),
      .pc_id(pc_id), .opnd_id(opnd_id), .hazard(hz0), .out_valid(ov0),
      .dest_ex(dx0), .ctl_ex(cx0), .val_rn_ex(rn0), .val_rm_ex(rm0),
      .pc_ex(pc0), .opnd_ex(op0)
   );

   id_ex_issue #(.FWD_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .two_src(two_src), .src1(src1), .src2(src2),
      .dest_id(dest_id), .ctl_id(ctl_id), .reg1(reg1), .reg2(reg2),
      .pc_id(pc_id), .opnd_id(opnd_id), .hazard(hz1), .out_valid(ov1),
      .dest_ex(dx1), .ctl_ex(cx1), .val_rn_ex(rn1), .val_rm_ex(rm1),
      .pc_ex(pc1), .opnd_ex(op1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic ts, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] d,
                         input logic [CTL_W-1:0] c, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] pc,
                         input logic [23:0] op);
      in_valid = v; two_src = ts; src1 = s1; src2 = s2; dest_id = d;
      ctl_id = c; reg1 = r1; reg2 = r2; pc_id = pc; opnd_id = op;
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1; freeze = 1'b0; flush = 1'b0;
      in_valid = 1'b0; two_src = 1'b0; src1 = '0; src2 = '0; dest_id = '0;
      ctl_id = '0; reg1 = '0; reg2 = '0; pc_id = '0; opnd_id = '0;

      // Reset state
      #2;
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_ctl_ex", 32'(cx0), 32'd0);
      chk("rst_hazard", 32'(hz0), 32'd0);
      #6 rst = 1'b0;

      // Simple issue into an empty pipe
      set_id(1, 0, 3, 0, 5, C_WB, 32'h11, 32'h22, 32'h104, 24'h00abcd);
      chk("a_hazard", 32'(hz0), 32'd0);
      step();
      chk("a_out_valid", 32'(ov0), 32'd1);
      chk("a_dest_ex", 32'(dx0), 32'd5);
      chk("a_val_rn", rn0, 32'h11);
      chk("a_val_rm", rm0, 32'h22);
      chk("a_ctl_ex", 32'(cx0), 32'(C_WB));
      chk("a_pc_ex", pc0, 32'h104);
      chk("a_opnd_ex", 32'(op0), 32'h00abcd);
      chk("a_fwd_out_valid", 32'(ov1), 32'd1);

      // RAW on EX dest 5: two bubbles without forwarding, none with
      set_id(1, 0, 5, 0, 7, C_WB, 32'h55, 32'h66, 32'h108, 24'h1);
      chk("b_hazard_ex", 32'(hz0), 32'd1);
      chk("b_fwd_hazard", 32'(hz1), 32'd0);
      step();
      chk("b_bubble1_valid", 32'(ov0), 32'd0);
      chk("b_bubble1_ctl", 32'(cx0), 32'd0);
      chk("b_bubble1_rn", rn0, 32'd0);
      chk("b_fwd_issue", 32'(dx1), 32'd7);
      chk("b_hazard_mem", 32'(hz0), 32'd1);
      chk("b_fwd_mem_ignored", 32'(hz1), 32'd0);
      step();
      chk("b_bubble2_valid", 32'(ov0), 32'd0);
      chk("b_hazard_clear", 32'(hz0), 32'd0);
      step();
      chk("b_issue_valid", 32'(ov0), 32'd1);
      chk("b_issue_dest", 32'(dx0), 32'd7);
      chk("b_issue_rn", rn0, 32'h55);

      // Reset pulse between edges with the pipe full
      rst = 1'b1;
      #1;
      chk("r_out_valid", 32'(ov0), 32'd0);
      chk("r_dest_ex", 32'(dx0), 32'd0);
      chk("r_val_rn", rn0, 32'd0);
      chk("r_fwd_out_valid", 32'(ov1), 32'd0);
      rst = 1'b0;
      set_id(1, 0, 7, 0, 9, C_LD, 32'h77, 32'h0, 32'h10c, 24'h2);
      chk("r_hazard", 32'(hz0), 32'd0);
      chk("r_fwd_hazard", 32'(hz1), 32'd0);
      step();
      chk("r_issue_valid", 32'(ov0), 32'd1);
      chk("r_issue_dest", 32'(dx0), 32'd9);

      // src2 only counts with two_src; load-use in EX
      set_id(1, 0, 2, 9, 4, C_WB, 32'h44, 32'h99, 32'h110, 24'h3);
      chk("s_one_src", 32'(hz0), 32'd0);
      chk("s_fwd_one_src", 32'(hz1), 32'd0);
      set_id(1, 1, 2, 9, 4, C_WB, 32'h44, 32'h99, 32'h110, 24'h3);
      chk("s_two_src", 32'(hz0), 32'd1);
      chk("s_fwd_load_use", 32'(hz1), 32'd1);
      step();
      chk("s_bubble_valid", 32'(ov0), 32'd0);
      chk("s_fwd_bubble_valid", 32'(ov1), 32'd0);
      chk("s_hazard_mem", 32'(hz0), 32'd1);
      chk("s_fwd_hazard_clear", 32'(hz1), 32'd0);
      step();
      chk("s_fwd_issue_valid", 32'(ov1), 32'd1);
      chk("s_fwd_issue_dest", 32'(dx1), 32'd4);
      chk("s_bubble2_valid", 32'(ov0), 32'd0);
      chk("s_hazard_clear", 32'(hz0), 32'd0);
      step();
      chk("s_issue_dest", 32'(dx0), 32'd4);
      chk("s_issue_rm", rm0, 32'h99);

      // Freeze holds everything, including the MEM slot
      set_id(1, 0, 0, 0, 15, C_WB, 32'hAA, 32'hBB, 32'h200, 24'h12);
      step();
      set_id(1, 0, 15, 0, 3, C_WB, 32'h33, 32'h0, 32'h204, 24'h13);
      chk("f_hazard_r15", 32'(hz0), 32'd1);
      chk("f_fwd_hazard", 32'(hz1), 32'd0);
      freeze = 1'b1;
      step();
      flush = 1'b1;
      step();
      step();
      chk("f_hold_valid", 32'(ov0), 32'd1);
      chk("f_hold_dest", 32'(dx0), 32'd15);
      chk("f_hold_rn", rn0, 32'hAA);
      chk("f_hold_pc", pc0, 32'h200);
      chk("f_fwd_hold_dest", 32'(dx1), 32'd15);
      flush = 1'b0;
      set_id(1, 0, 4, 0, 3, C_WB, 32'h33, 32'h0, 32'h204, 24'h13);
      chk("f_mem_slot_held", 32'(hz0), 32'd1);
      flush = 1'b1;
      freeze = 1'b0;
      set_id(1, 0, 15, 0, 3, C_WB, 32'h33, 32'h0, 32'h204, 24'h13);
      chk("f_flush_hazard", 32'(hz0), 32'd0);
      step();
      chk("f_flush_valid", 32'(ov0), 32'd0);
      chk("f_flush_ctl", 32'(cx0), 32'd0);
      chk("f_flush_dest", 32'(dx0), 32'd0);
      chk("f_flush_rn", rn0, 32'd0);
      chk("f_fwd_flush_valid", 32'(ov1), 32'd0);
      flush = 1'b0;
      #1;
      chk("f_mem_after_flush", 32'(hz0), 32'd1);
      chk("f_fwd_mem_after_flush", 32'(hz1), 32'd0);
      in_valid = 1'b0;
      #1;
      chk("f_invalid_no_hazard", 32'(hz0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
